data_cache: RTL and testbench

- Parametrised direct-mapped, write-through, no-write-allocate data cache.
- Sits between the CPU datapath (ALU result as address, rs2 as write data) and a variable-latency data memory.
- Supports word and byte (addr_mode) accesses and asserts a stall back to the PC/pipeline while a memory transaction is outstanding.
- Carries saturating hit/miss counters for performance evaluation.

---
 rtl/data_cache.sv | 199 +++++++++++++++++++
 tb/tb_data_cache.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache, one word per line.
// Read hits return data in the same cycle; misses and all stores stall the CPU until mem_ack.
module data_cache #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int INDEX_BITS    = 3,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cpu_re,
    input  logic                      cpu_we,
    input  logic [ADDRESS_WIDTH-1:0]  cpu_addr,
    input  logic [DATA_WIDTH-1:0]     cpu_wdata,
    input  logic                      addr_mode,
    input  logic                      flush,
    output logic [DATA_WIDTH-1:0]     cpu_rdata,
    output logic                      stall,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDRESS_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic [DATA_WIDTH/8-1:0]   mem_be,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    input  logic                      mem_ack,
    output logic [COUNT_WIDTH-1:0]    hit_count,
    output logic [COUNT_WIDTH-1:0]    miss_count
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = ADDRESS_WIDTH - INDEX_BITS - 2;
    localparam int BE_W     = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;

    state_t                   state_q, state_d;
    logic [LINES-1:0]         valid_q, valid_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic                     mem_req_q, mem_req_d;
    logic                     mem_we_q, mem_we_d;
    logic [BE_W-1:0]          mem_be_q, mem_be_d;
    logic [COUNT_WIDTH-1:0]   hit_q, hit_d;
    logic [COUNT_WIDTH-1:0]   miss_q, miss_d;

    logic [TAG_BITS-1:0]      tag_mem  [LINES];
    logic [DATA_WIDTH-1:0]    data_mem [LINES];

    logic [1:0]               offset;
    logic [INDEX_BITS-1:0]    index;
    logic [TAG_BITS-1:0]      tag;
    logic [DATA_WIDTH-1:0]    line_data;
    logic                     line_hit;
    logic [BE_W-1:0]          byte_be;
    logic [DATA_WIDTH-1:0]    wdata_lanes;
    logic [DATA_WIDTH-1:0]    merged_data;

    logic                     line_we;
    logic [DATA_WIDTH-1:0]    line_wdata;
    logic                     stall_c;
    logic [DATA_WIDTH-1:0]    cpu_rdata_c;

    assign offset    = cpu_addr[1:0];
    assign index     = cpu_addr[INDEX_BITS+1:2];
    assign tag       = cpu_addr[ADDRESS_WIDTH-1:INDEX_BITS+2];
    assign line_data = data_mem[index];
    assign line_hit  = valid_q[index] && (tag_mem[index] == tag);
    assign byte_be   = BE_W'(1) << offset;

    assign wdata_lanes = addr_mode ? {BE_W{cpu_wdata[7:0]}} : cpu_wdata;

    // Store merge into a hitting line: only lanes the memory write enabled change.
    generate
        for (genvar gi = 0; gi < BE_W; gi++) begin : g_merge
            assign merged_data[8*gi +: 8] = mem_be_q[gi] ? wdata_lanes[8*gi +: 8]
                                                         : line_data[8*gi +: 8];
        end
    endgenerate

    function automatic logic [DATA_WIDTH-1:0] extract(input logic [DATA_WIDTH-1:0] word,
                                                      input logic mode,
                                                      input logic [1:0] off);
        logic [DATA_WIDTH-1:0] shifted;
        shifted = word >> {off, 3'b000};
        return mode ? {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]} : word;
    endfunction

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        rdata_d     = rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        hit_d       = hit_q;
        miss_d      = miss_q;
        line_we     = 1'b0;
        line_wdata  = mem_rdata;
        stall_c     = 1'b0;
        cpu_rdata_c = rdata_q;

        case (state_q)
            IDLE: begin
                if (cpu_we) begin
                    stall_c   = 1'b1;
                    state_d   = WR_THRU;
                    mem_req_d = 1'b1;
                    mem_we_d  = 1'b1;
                    mem_be_d  = addr_mode ? byte_be : '1;
                end else if (cpu_re) begin
                    if (line_hit) begin
                        cpu_rdata_c = extract(line_data, addr_mode, offset);
                        rdata_d     = cpu_rdata_c;
                        if (hit_q != '1) hit_d = hit_q + 1'b1;
                    end else begin
                        stall_c   = 1'b1;
                        state_d   = RD_MISS;
                        mem_req_d = 1'b1;
                        mem_we_d  = 1'b0;
                        mem_be_d  = '1;
                        if (miss_q != '1) miss_d = miss_q + 1'b1;
                    end
                end
            end
            RD_MISS: begin
                if (mem_ack) begin
                    line_we        = 1'b1;
                    line_wdata     = mem_rdata;
                    valid_d[index] = 1'b1;
                    cpu_rdata_c    = extract(mem_rdata, addr_mode, offset);
                    rdata_d        = cpu_rdata_c;
                    state_d        = IDLE;
                    mem_req_d      = 1'b0;
                    mem_we_d       = 1'b0;
                    mem_be_d       = '0;
                end else begin
                    stall_c = 1'b1;
                end
            end
            WR_THRU: begin
                if (mem_ack) begin
                    if (line_hit) begin
                        line_we    = 1'b1;
                        line_wdata = merged_data;
                    end
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    mem_be_d  = '0;
                end else begin
                    stall_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush overrides any valid bit set by a coinciding refill.
        if (flush) valid_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            valid_q   <= '0;
            rdata_q   <= '0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_be_q  <= '0;
            hit_q     <= '0;
            miss_q    <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            rdata_q   <= rdata_d;
            mem_req_q <= mem_req_d;
            mem_we_q  <= mem_we_d;
            mem_be_q  <= mem_be_d;
            hit_q     <= hit_d;
            miss_q    <= miss_d;
        end
    end

    // Tag/data storage carries no reset; valid_q alone qualifies it.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_mem[index]  <= tag;
            data_mem[index] <= line_wdata;
        end
    end

    assign cpu_rdata  = cpu_rdata_c;
    assign stall      = stall_c;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_be     = mem_be_q;
    assign mem_addr   = {cpu_addr[ADDRESS_WIDTH-1:2], 2'b00};
    assign mem_wdata  = wdata_lanes;
    assign hit_count  = hit_q;
    assign miss_count = miss_q;

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: a responder acks the Nth cycle of mem_req and
// every observed value is compared against a hand-computed constant.
module tb_data_cache;
    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_re, cpu_we, addr_mode, flush;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        stall, mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic [15:0] hit_count, miss_count;

    int n_checks = 0;
    int n_errors = 0;

    int          t_stalls, t_reqs;
    logic [31:0] t_rdata, t_wd, t_addr;
    logic [3:0]  t_be;
    logic        t_we, t_done;

    always #5 clk = ~clk;

    data_cache dut (
        .clk(clk), .rst(rst),
        .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .addr_mode(addr_mode), .flush(flush), .cpu_rdata(cpu_rdata), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // One CPU access; memory acks the lat-th cycle of mem_req, optionally with flush.
    task automatic access(input logic we, input logic re, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic mode, input int lat,
                          input logic [31:0] mrd, input logic fl);
        @(negedge clk);
        cpu_we = we; cpu_re = re; cpu_addr = addr; cpu_wdata = wdata; addr_mode = mode;
        t_stalls = 0; t_reqs = 0; t_done = 1'b0; t_rdata = '0;
        t_be = '0; t_wd = '0; t_addr = '0; t_we = 1'b0;
        for (int cyc = 0; cyc < 64 && !t_done; cyc++) begin
            #1;
            if (mem_req) begin
                t_reqs++;
                t_be = mem_be; t_wd = mem_wdata; t_addr = mem_addr; t_we = mem_we;
                if (t_reqs == lat) begin
                    mem_ack = 1'b1; mem_rdata = mrd; flush = fl;
                    #1;
                end
            end
            if (stall) t_stalls++;
            else begin
                t_rdata = cpu_rdata;
                t_done  = 1'b1;
            end
            @(negedge clk);
            mem_ack = 1'b0; flush = 1'b0;
        end
        check("access_done", t_done, 1'b1);
        cpu_we = 1'b0; cpu_re = 1'b0;
        $display("access we=%0d re=%0d addr=0x%08h mode=%0d stalls=%0d rdata=0x%08h hits=%0d misses=%0d",
                 we, re, addr, mode, t_stalls, t_rdata, hit_count, miss_count);
    endtask

    initial begin
        rst = 1'b1; cpu_re = 0; cpu_we = 0; addr_mode = 0; flush = 0;
        cpu_addr = '0; cpu_wdata = '0; mem_ack = 0; mem_rdata = '0;
        #2 rst = 1'b0;
        #10;
        check("rst_stall", stall, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_be", mem_be, 0);
        check("rst_rdata", cpu_rdata, 0);
        check("rst_hits", hit_count, 0);
        check("rst_misses", miss_count, 0);
        @(negedge clk); rst = 1'b1;

        // Cold read miss then hit
        access(0, 1, 32'h40, 0, 0, 3, 32'hDEADBEEF, 0);
        check("cold_stalls", t_stalls, 3);
        check("cold_rdata", t_rdata, 32'hDEADBEEF);
        check("cold_mem_addr", t_addr, 32'h40);
        check("cold_mem_be", t_be, 4'hF);
        check("cold_mem_we", t_we, 0);
        check("cold_misses", miss_count, 1);
        access(0, 1, 32'h40, 0, 0, 1, 32'h0, 0);
        check("hit_stalls", t_stalls, 0);
        check("hit_no_req", t_reqs, 0);
        check("hit_rdata", t_rdata, 32'hDEADBEEF);
        check("hit_count1", hit_count, 1);

        // Byte store into cached line
        access(1, 0, 32'h42, 32'h0000_00AB, 1, 2, 32'h0, 0);
        check("bw_stalls", t_stalls, 2);
        check("bw_mem_be", t_be, 4'b0100);
        check("bw_mem_wdata", t_wd, 32'hABABABAB);
        check("bw_mem_addr", t_addr, 32'h40);
        check("bw_mem_we", t_we, 1);
        access(0, 1, 32'h42, 0, 1, 1, 32'h0, 0);
        check("br_rdata", t_rdata, 32'h0000_00AB);
        check("br_stalls", t_stalls, 0);
        access(0, 1, 32'h40, 0, 0, 1, 32'h0, 0);
        check("wr_merged", t_rdata, 32'hDEABBEEF);
        check("hit_count3", hit_count, 3);

        // Store to uncached line does not allocate
        access(1, 0, 32'h80, 32'h12345678, 0, 1, 32'h0, 0);
        check("uw_mem_be", t_be, 4'hF);
        check("uw_mem_wdata", t_wd, 32'h12345678);
        check("uw_stalls", t_stalls, 1);
        access(0, 1, 32'h80, 0, 0, 2, 32'h55, 0);
        check("ur_rdata", t_rdata, 32'h55);
        check("ur_misses", miss_count, 2);

        // Conflict misses on index 0
        access(0, 1, 32'h40, 0, 0, 1, 32'h11111111, 0);
        access(0, 1, 32'h60, 0, 0, 1, 32'h22222222, 0);
        access(0, 1, 32'h40, 0, 0, 1, 32'h33333333, 0);
        check("cf_rdata", t_rdata, 32'h33333333);
        check("cf_misses", miss_count, 5);
        check("cf_hits", hit_count, 3);

        // Flush coinciding with refill ack
        access(0, 1, 32'h100, 0, 0, 2, 32'hCAFEF00D, 1);
        check("fl_rdata", t_rdata, 32'hCAFEF00D);
        check("fl_misses", miss_count, 6);
        access(0, 1, 32'h103, 0, 1, 1, 32'h0BADF00D, 0);
        check("fl_remiss", miss_count, 7);
        check("fl_byte3", t_rdata, 32'h0000_000B);

        // Reset in the middle of a read miss, then a stray ack
        @(negedge clk); cpu_re = 1'b1; cpu_addr = 32'h200; addr_mode = 1'b0;
        @(negedge clk); @(negedge clk);
        check("mid_req", mem_req, 1);
        cpu_re = 1'b0; rst = 1'b0; #1;
        check("mid_rst_req", mem_req, 0);
        check("mid_rst_stall", stall, 0);
        check("mid_rst_misses", miss_count, 0);
        check("mid_rst_hits", hit_count, 0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF; #1;
        check("stray_stall", stall, 0);
        @(negedge clk); mem_ack = 1'b0;
        check("stray_req", mem_req, 0);
        check("stray_rdata", cpu_rdata, 0);
        check("stray_misses", miss_count, 0);
        access(0, 1, 32'h40, 0, 0, 1, 32'h77, 0);
        check("post_rst_miss", miss_count, 1);
        access(0, 1, 32'h200, 0, 0, 1, 32'h99, 0);
        check("post_rst_miss2", miss_count, 2);

        // Hit counter saturation
        @(negedge clk); cpu_re = 1'b1; cpu_addr = 32'h200; addr_mode = 1'b0;
        repeat (65540) @(negedge clk);
        check("sat_stall", stall, 0);
        cpu_re = 1'b0;
        check("sat_hits", hit_count, 16'hFFFF);
        check("sat_misses", miss_count, 2);
        $display("saturation hits=0x%04h", hit_count);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
